// File: rtl/eth_frame_log_pkg.sv
// Shared definitions for the frame log arbiter: descriptor field layout,
// header size, FSM state type and the data-word-count helper.
package eth_frame_log_pkg;

    // Descriptor word layout {MATCHED, SIZE, NUMBER, TIMESTAMP}
    localparam int C_CTL_BITS    = 120;
    localparam int C_TS_LSB      = 0;
    localparam int C_TS_MSB      = 63;
    localparam int C_NUM_LSB     = 64;
    localparam int C_NUM_MSB     = 95;
    localparam int C_SIZE_LSB    = 96;
    localparam int C_SIZE_MSB    = 111;
    localparam int C_MATCH_LSB   = 112;
    localparam int C_MATCH_MSB   = 119;

    // Header is the descriptor padded with the source index to 128 bits
    localparam int C_LOG_HDR_BITS = 128;
    localparam int C_SRC_IDX_BITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA
    } log_arb_state_t;

    // Number of W-bit words needed for a SIZE-byte frame; 17 bits so that
    // SIZE=65535 plus rounding cannot overflow.
    function automatic logic [16:0] data_words(input logic [15:0] size, input int shift);
        logic [16:0] padded;
        padded = {1'b0, size} + ((17'd1 << shift) - 17'd1);
        return padded >> shift;
    endfunction

endpackage

// File: rtl/eth_frame_log_arbiter_rr.sv
// Combinational round-robin picker: first requester strictly after the
// pointer, wrapping, returned both one-hot and as an index.
module rr_arbiter
    import eth_frame_log_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]                req,
    input  logic [C_SRC_IDX_BITS-1:0]   ptr,
    output logic [N-1:0]                grant,
    output logic [C_SRC_IDX_BITS-1:0]   grant_idx,
    output logic                        any_req
);

    // Pad requests to 8 entries so a 3-bit index always addresses a real slot
    logic req_arr [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_req
        if (gi < N) begin : g_real
            assign req_arr[gi] = req[gi];
        end else begin : g_pad
            assign req_arr[gi] = 1'b0;
        end
    end

    logic [C_SRC_IDX_BITS-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = '0;
        for (int off = N; off >= 1; off--) begin
            cand = C_SRC_IDX_BITS'((int'(ptr) + off) % N);
            if (req_arr[cand]) begin
                grant_idx = cand;
                any_req   = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant[gi] = any_req && (grant_idx == C_SRC_IDX_BITS'(gi));
    end

endmodule

// File: rtl/eth_frame_log_arbiter.sv
// Merges per-source (descriptor, frame) streams into one log stream:
// round-robin grant, header words then frame words, tlast on the final word.
module eth_frame_log_arbiter
    import eth_frame_log_pkg::*;
#(
    parameter int C_NUM_SOURCES    = 2,
    parameter int C_AXIS_LOG_WIDTH = 64
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      enable,
    input  logic [C_CTL_BITS*C_NUM_SOURCES-1:0]       s_axis_ctl_tdata,
    input  logic [C_NUM_SOURCES-1:0]                  s_axis_ctl_tvalid,
    output logic [C_NUM_SOURCES-1:0]                  s_axis_ctl_tready,
    input  logic [C_AXIS_LOG_WIDTH*C_NUM_SOURCES-1:0] s_axis_frame_tdata,
    input  logic [C_NUM_SOURCES-1:0]                  s_axis_frame_tvalid,
    output logic [C_NUM_SOURCES-1:0]                  s_axis_frame_tready,
    output logic [C_AXIS_LOG_WIDTH-1:0]               m_axis_tdata,
    output logic                                      m_axis_tlast,
    output logic                                      m_axis_tvalid,
    input  logic                                      m_axis_tready,
    output logic [31:0]                               packet_count
);

    localparam int N   = C_NUM_SOURCES;
    localparam int W   = C_AXIS_LOG_WIDTH;
    localparam int BSH = $clog2(W / 8);
    localparam int H   = C_LOG_HDR_BITS / W;
    localparam logic [1:0] LAST_HDR = 2'(H - 1);
    localparam logic [C_SRC_IDX_BITS-1:0] PTR_INIT = C_SRC_IDX_BITS'(N - 1);

    log_arb_state_t state_reg, state_next;

    logic [C_SRC_IDX_BITS-1:0] ptr_reg;
    logic [C_SRC_IDX_BITS-1:0] grant_idx_reg;
    logic [N-1:0]              grant_oh_reg;
    logic [C_CTL_BITS-1:0]     ctl_reg;
    logic [16:0]               remain_reg;
    logic [1:0]                hdr_idx_reg;

    logic [W-1:0] tdata_reg;
    logic         tvalid_reg;
    logic         tlast_reg;
    logic [31:0]  count_reg;

    // Per-source views padded to 8 so a 3-bit grant index selects directly
    logic [C_CTL_BITS-1:0] ctl_arr   [8];
    logic [W-1:0]          frame_arr [8];
    logic                  fvalid_arr[8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_src
        if (gi < N) begin : g_real
            assign ctl_arr[gi]    = s_axis_ctl_tdata[gi*C_CTL_BITS +: C_CTL_BITS];
            assign frame_arr[gi]  = s_axis_frame_tdata[gi*W +: W];
            assign fvalid_arr[gi] = s_axis_frame_tvalid[gi];
        end else begin : g_pad
            assign ctl_arr[gi]    = '0;
            assign frame_arr[gi]  = '0;
            assign fvalid_arr[gi] = 1'b0;
        end
    end

    // Header split into W-bit words, least-significant word first
    logic [C_LOG_HDR_BITS-1:0] hdr_full;
    logic [W-1:0]              hdr_words [4];

    assign hdr_full = {5'b0, grant_idx_reg, ctl_reg};

    for (genvar gi = 0; gi < 4; gi++) begin : g_hdr
        if (gi < H) begin : g_real
            assign hdr_words[gi] = hdr_full[gi*W +: W];
        end else begin : g_pad
            assign hdr_words[gi] = '0;
        end
    end

    logic [N-1:0]              arb_grant;
    logic [C_SRC_IDX_BITS-1:0] arb_idx;
    logic                      arb_any;

    rr_arbiter #(.N(N)) u_rr (
        .req       (s_axis_ctl_tvalid),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    logic         load_en;
    logic         start;
    logic         ctl_pop;
    logic         frame_rdy;
    logic         out_load;
    logic         out_last;
    logic [W-1:0] out_data;

    assign load_en = ~tvalid_reg | m_axis_tready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus the word to load into the output register this cycle
    always_comb begin
        state_next = state_reg;
        start      = 1'b0;
        ctl_pop    = 1'b0;
        frame_rdy  = 1'b0;
        out_load   = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (enable && arb_any) begin
                    start      = 1'b1;
                    state_next = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (load_en) begin
                    out_load = 1'b1;
                    out_data = hdr_words[hdr_idx_reg];
                    if (hdr_idx_reg == LAST_HDR) begin
                        ctl_pop    = 1'b1;
                        out_last   = (remain_reg == 17'd0);
                        state_next = (remain_reg == 17'd0) ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                frame_rdy = load_en;
                if (load_en && fvalid_arr[grant_idx_reg]) begin
                    out_load = 1'b1;
                    out_data = frame_arr[grant_idx_reg];
                    out_last = (remain_reg == 17'd1);
                    if (remain_reg == 17'd1) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Grant bookkeeping: latch winner and its descriptor, count header/data words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg       <= PTR_INIT;
            grant_idx_reg <= '0;
            grant_oh_reg  <= '0;
            ctl_reg       <= '0;
            remain_reg    <= '0;
            hdr_idx_reg   <= '0;
        end else begin
            if (start) begin
                ptr_reg       <= arb_idx;
                grant_idx_reg <= arb_idx;
                grant_oh_reg  <= arb_grant;
                ctl_reg       <= ctl_arr[arb_idx];
                remain_reg    <= data_words(ctl_arr[arb_idx][C_SIZE_MSB:C_SIZE_LSB], BSH);
                hdr_idx_reg   <= '0;
            end else if (state_reg == ST_HEADER && load_en) begin
                hdr_idx_reg <= hdr_idx_reg + 2'd1;
            end else if (state_reg == ST_DATA && out_load) begin
                remain_reg <= remain_reg - 17'd1;
            end
        end
    end

    // Output register: refill whenever empty or being accepted, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tdata_reg  <= '0;
            tvalid_reg <= 1'b0;
            tlast_reg  <= 1'b0;
        end else if (load_en) begin
            tvalid_reg <= out_load;
            tlast_reg  <= out_load & out_last;
            if (out_load) begin
                tdata_reg <= out_data;
            end
        end
    end

    // Count packets as their tlast word is accepted downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (tvalid_reg && m_axis_tready && tlast_reg) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign s_axis_ctl_tready   = ctl_pop   ? grant_oh_reg : '0;
    assign s_axis_frame_tready = frame_rdy ? grant_oh_reg : '0;
    assign m_axis_tdata        = tdata_reg;
    assign m_axis_tvalid       = tvalid_reg;
    assign m_axis_tlast        = tlast_reg;
    assign packet_count        = count_reg;

endmodule

// File: tb/tb_eth_frame_log_arbiter.sv
// Scoreboard bench for eth_frame_log_arbiter (N=2, W=64): per-source
// driver queues, expected packets computed from descriptors, monitor
// reassembles output packets and compares them.
module tb_eth_frame_log_arbiter;

    localparam int N  = 2;
    localparam int W  = 64;
    localparam int CB = 120;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n        = 1'b0;
    logic              enable       = 1'b0;
    logic [CB*N-1:0]   ctl_tdata    = '0;
    logic [N-1:0]      ctl_tvalid   = '0;
    logic [N-1:0]      ctl_tready;
    logic [W*N-1:0]    frame_tdata  = '0;
    logic [N-1:0]      frame_tvalid = '0;
    logic [N-1:0]      frame_tready;
    logic [W-1:0]      m_axis_tdata;
    logic              m_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic [31:0]       packet_count;

    eth_frame_log_arbiter #(
        .C_NUM_SOURCES    (N),
        .C_AXIS_LOG_WIDTH (W)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .enable              (enable),
        .s_axis_ctl_tdata    (ctl_tdata),
        .s_axis_ctl_tvalid   (ctl_tvalid),
        .s_axis_ctl_tready   (ctl_tready),
        .s_axis_frame_tdata  (frame_tdata),
        .s_axis_frame_tvalid (frame_tvalid),
        .s_axis_frame_tready (frame_tready),
        .m_axis_tdata        (m_axis_tdata),
        .m_axis_tlast        (m_axis_tlast),
        .m_axis_tvalid       (m_axis_tvalid),
        .m_axis_tready       (m_axis_tready),
        .packet_count        (packet_count)
    );

    int checks   = 0;
    int failures = 0;

    // Source-side queues and expected output ({tlast, data}) per source
    logic [CB-1:0] ctl_q0[$], ctl_q1[$];
    logic [W-1:0]  fr_q0[$], fr_q1[$];
    logic [W:0]    exp_q0[$], exp_q1[$];
    logic [W:0]    pkt_q[$];
    int            order_q[$];

    bit        rdy_rand   = 1'b0;
    bit        gap_rand   = 1'b0;
    int        cyc        = 0;
    int        rise_cyc   = 0;
    bit        lat_armed  = 1'b0;
    bit        watch1     = 1'b0;
    bit        seen_ftr1  = 1'b0;
    int        words_seen = 0;
    int        mdl_count  = 0;
    logic [N-1:0] hs_c, hs_f;
    bit        prev_c0;
    bit        prev_stall = 1'b0;
    logic [W:0] prev_word = '0;
    bit        cnt_pend   = 1'b0;

    task automatic chk(input bit ok, input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=0x%0h required=0x%0h", name, got, req);
        end
    endtask

    // Queue one packet on a source and its expected output words
    task automatic push_packet(input int src, input int size);
        logic [CB-1:0]  ctl;
        logic [127:0]   hdr;
        logic [W-1:0]   w;
        logic [W:0]     e0, e1;
        int             d;
        ctl = {8'($urandom), 16'(size), $urandom, $urandom, $urandom};
        hdr = {5'b0, 3'(src), ctl};
        d   = (size + 7) / 8;
        e0  = {1'b0, hdr[63:0]};
        e1  = {(d == 0), hdr[127:64]};
        if (src == 0) begin exp_q0.push_back(e0); exp_q0.push_back(e1); end
        else          begin exp_q1.push_back(e0); exp_q1.push_back(e1); end
        for (int k = 0; k < d; k++) begin
            w = {$urandom, $urandom};
            if (src == 0) begin fr_q0.push_back(w); exp_q0.push_back({(k == d - 1), w}); end
            else          begin fr_q1.push_back(w); exp_q1.push_back({(k == d - 1), w}); end
        end
        if (src == 0) ctl_q0.push_back(ctl);
        else          ctl_q1.push_back(ctl);
        $display("tx: src=%0d size=%0d data_words=%0d", src, size, d);
    endtask

    // Compare a completed output packet against the head of its source's expectations
    task automatic check_packet();
        int n, src, bad;
        logic [W:0] e, g_bad, e_bad;
        bit none;
        n = pkt_q.size();
        bad = -1; g_bad = '0; e_bad = '0;
        if (n < 2) begin
            chk(1'b0, "packet_length", 128'(n), 128'd2);
            pkt_q.delete();
            return;
        end
        src = int'(pkt_q[1][58:56]);
        if (order_q.size() > 0) begin
            int es;
            es = order_q.pop_front();
            chk(src == es, "grant_order", 128'(src), 128'(es));
        end
        for (int i = 0; i < n; i++) begin
            none = 1'b0;
            e = '0;
            if (src == 0 && exp_q0.size() > 0)      e = exp_q0.pop_front();
            else if (src == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            else none = 1'b1;
            if ((none || e != pkt_q[i]) && bad < 0) begin
                bad = i; g_bad = pkt_q[i]; e_bad = e;
            end
        end
        chk(bad < 0, $sformatf("packet_words src%0d word%0d", src, bad), 128'(g_bad), 128'(e_bad));
        $display("rx: src=%0d words=%0d", src, n);
        pkt_q.delete();
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!(exp_q0.size() == 0 && exp_q1.size() == 0 && pkt_q.size() == 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(n < budget, {name, "_timeout"}, 128'(exp_q0.size() + exp_q1.size()), 128'd0);
        repeat (3) @(negedge clk);
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Source and sink driver: pop on observed handshakes, present queue heads
    initial forever begin
        @(negedge clk);
        hs_c = ctl_tvalid & ctl_tready;
        hs_f = frame_tvalid & frame_tready;
        @(posedge clk);
        #1;
        if (hs_c[0] && ctl_q0.size() > 0) void'(ctl_q0.pop_front());
        if (hs_c[1] && ctl_q1.size() > 0) void'(ctl_q1.pop_front());
        if (hs_f[0] && fr_q0.size() > 0)  void'(fr_q0.pop_front());
        if (hs_f[1] && fr_q1.size() > 0)  void'(fr_q1.pop_front());
        prev_c0 = ctl_tvalid[0];
        ctl_tvalid[0]         = (ctl_q0.size() > 0);
        ctl_tdata[0*CB +: CB] = (ctl_q0.size() > 0) ? ctl_q0[0] : '0;
        ctl_tvalid[1]         = (ctl_q1.size() > 0);
        ctl_tdata[1*CB +: CB] = (ctl_q1.size() > 0) ? ctl_q1[0] : '0;
        if (!prev_c0 && ctl_tvalid[0]) rise_cyc = cyc;
        frame_tvalid[0]       = (fr_q0.size() > 0) && (!gap_rand || $urandom_range(0, 3) != 0);
        frame_tdata[0*W +: W] = (fr_q0.size() > 0) ? fr_q0[0] : '0;
        frame_tvalid[1]       = (fr_q1.size() > 0) && (!gap_rand || $urandom_range(0, 3) != 0);
        frame_tdata[1*W +: W] = (fr_q1.size() > 0) ? fr_q1[0] : '0;
        m_axis_tready         = !rdy_rand || ($urandom_range(0, 1) == 1);
    end

    // Monitor: reassemble packets, check count, stall hold, latency, tready exclusivity
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            pkt_q.delete();
            mdl_count  = 0;
            prev_stall = 1'b0;
            cnt_pend   = 1'b0;
        end else begin
            if (cnt_pend) begin
                chk(packet_count == 32'(mdl_count), "packet_count", 128'(packet_count), 128'(mdl_count));
                cnt_pend = 1'b0;
            end
            if (prev_stall) begin
                chk(m_axis_tvalid && ({m_axis_tlast, m_axis_tdata} == prev_word), "stall_hold",
                    128'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}), 128'({1'b1, prev_word}));
            end
            if (lat_armed && m_axis_tvalid) begin
                chk((cyc - rise_cyc) == 2, "first_word_latency", 128'(cyc - rise_cyc), 128'd2);
                lat_armed = 1'b0;
            end
            if (|{ctl_tready, frame_tready}) begin
                chk($countones({ctl_tready, frame_tready}) <= 1, "tready_single_source",
                    128'({ctl_tready, frame_tready}), 128'd1);
            end
            if (watch1 && frame_tready[1]) seen_ftr1 = 1'b1;
            if (m_axis_tvalid && m_axis_tready) begin
                pkt_q.push_back({m_axis_tlast, m_axis_tdata});
                words_seen++;
                if (m_axis_tlast) begin
                    check_packet();
                    mdl_count++;
                    cnt_pend = 1'b1;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_word  = {m_axis_tlast, m_axis_tdata};
        end
    end

    task automatic check_outputs_zero(input string tag);
        chk(m_axis_tvalid == 1'b0, {tag, "_tvalid"}, 128'(m_axis_tvalid), 128'd0);
        chk(m_axis_tdata == '0,    {tag, "_tdata"},  128'(m_axis_tdata),  128'd0);
        chk(m_axis_tlast == 1'b0,  {tag, "_tlast"},  128'(m_axis_tlast),  128'd0);
        chk(packet_count == 32'd0, {tag, "_count"},  128'(packet_count),  128'd0);
        chk(ctl_tready == '0,      {tag, "_ctl_tready"},   128'(ctl_tready),   128'd0);
        chk(frame_tready == '0,    {tag, "_frame_tready"}, 128'(frame_tready), 128'd0);
    endtask

    initial begin
        int n, base;
        repeat (3) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        @(posedge clk);
        #3 rst_n = 1'b1;

        // Single packet, first-word latency from an idle, empty output
        enable = 1'b1;
        @(negedge clk);
        lat_armed = 1'b1;
        push_packet(0, 13);
        wait_done(200, "single");

        // Zero-size packet on source 1 with a stray frame word that must stay put
        watch1 = 1'b1;
        seen_ftr1 = 1'b0;
        fr_q1.push_back(64'hdead_beef_0bad_f00d);
        push_packet(1, 0);
        wait_done(200, "size0");
        watch1 = 1'b0;
        chk(!seen_ftr1, "size0_frame_tready", 128'(seen_ftr1), 128'd0);
        chk(fr_q1.size() == 1, "size0_stray_word_kept", 128'(fr_q1.size()), 128'd1);
        fr_q1.delete();
        repeat (2) @(negedge clk);

        // Backpressure and frame gaps
        rdy_rand = 1'b1;
        gap_rand = 1'b1;
        push_packet(0, 64);
        wait_done(1000, "stall");
        rdy_rand = 1'b0;
        gap_rand = 1'b0;

        // Enable dropped during the header: packet completes, src1 waits
        push_packet(0, 20);
        n = 0;
        while (!m_axis_tvalid && n < 50) begin @(negedge clk); n++; end
        chk(n < 50, "enable_header_start", 128'(n), 128'd50);
        enable = 1'b0;
        push_packet(1, 8);
        n = 0;
        while (exp_q0.size() != 0 && n < 200) begin @(negedge clk); n++; end
        chk(n < 200, "enable_src0_done", 128'(exp_q0.size()), 128'd0);
        repeat (20) @(negedge clk);
        chk(ctl_q1.size() == 1, "enable_src1_held", 128'(ctl_q1.size()), 128'd1);
        chk(exp_q1.size() == 3, "enable_src1_no_output", 128'(exp_q1.size()), 128'd3);
        chk(m_axis_tvalid == 1'b0, "enable_idle_tvalid", 128'(m_axis_tvalid), 128'd0);
        enable = 1'b1;
        wait_done(300, "enable");

        // Random mix
        rdy_rand = 1'b1;
        gap_rand = 1'b1;
        for (int i = 0; i < 8; i++) push_packet(int'($urandom_range(0, 1)), int'($urandom_range(0, 100)));
        wait_done(6000, "random");
        rdy_rand = 1'b0;
        gap_rand = 1'b0;

        // Maximum size: 8192 data words at W=64
        push_packet(1, 65535);
        wait_done(12000, "max_size");

        // Reset in the data phase of a SIZE=40 packet
        push_packet(0, 40);
        base = words_seen;
        n = 0;
        while (words_seen < base + 3 && n < 100) begin @(negedge clk); n++; end
        chk(n < 100, "reset_reach_data", 128'(words_seen - base), 128'd3);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        ctl_q0.delete(); ctl_q1.delete(); fr_q0.delete(); fr_q1.delete();
        exp_q0.delete(); exp_q1.delete(); order_q.delete();
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Both sources loaded: strict alternation starting from source 0
        for (int k = 0; k < 3; k++) begin
            push_packet(0, int'($urandom_range(0, 30)));
            push_packet(1, int'($urandom_range(0, 30)));
            order_q.push_back(0);
            order_q.push_back(1);
        end
        wait_done(1000, "round_robin");
        chk(order_q.size() == 0, "round_robin_all_seen", 128'(order_q.size()), 128'd0);
        chk(packet_count == 32'd6, "final_packet_count", 128'(packet_count), 128'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "global timeout");
    end

endmodule
